// File: rtl/shift_seq_ctrl.sv
// Command sequencer for an external 4-bit rotator: runs cmd_pass rotate passes, then holds the result on a
// valid/ready port. Optional build macro SHIFT_ABORT_EN adds an abort input that cancels a running command.
`timescale 1ns/1ps

module shift_seq_ctrl #(
  parameter int PASS_W = 3
) (
  input  logic              clk,
  input  logic              rst,
`ifdef SHIFT_ABORT_EN
  input  logic              abort,
`endif
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_a,
  input  logic [1:0]        cmd_amt,
  input  logic              cmd_dir,
  input  logic [PASS_W-1:0] cmd_pass,
  output logic [3:0]        sh_a,
  output logic [1:0]        sh_s,
  output logic              sh_dir,
  output logic              sh_en,
  input  logic [3:0]        sh_q,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [3:0]        res_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ROT,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [PASS_W-1:0]   rem_q, rem_d;
  logic [3:0]          sh_a_q, sh_a_d;
  logic [1:0]          sh_s_q, sh_s_d;
  logic                sh_dir_q, sh_dir_d;
  logic [3:0]          res_data_q, res_data_d;
  logic                abort_req;

`ifdef SHIFT_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // sh_a_q doubles as the working value: it is the operand of the current pass and is frozen
  // on the final pass so the rotator inputs hold their last values outside ROT.
  always_comb begin
    // NOTE: every next-state value defaults to its register first, so no path infers a latch.
    state_d    = state_q;
    rem_d      = rem_q;
    sh_a_d     = sh_a_q;
    sh_s_d     = sh_s_q;
    sh_dir_d   = sh_dir_q;
    res_data_d = res_data_q;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          rem_d = cmd_pass;
          if (cmd_pass != '0) begin
            state_d  = S_ROT;
            sh_a_d   = cmd_a;
            sh_s_d   = cmd_amt;
            sh_dir_d = cmd_dir;
          end else begin
            state_d    = S_DONE;
            res_data_d = cmd_a;
          end
        end
      end
      S_ROT: begin
        if (abort_req) begin
          state_d = S_IDLE;
        end else begin
          rem_d = rem_q - PASS_W'(1);
          if (rem_q == PASS_W'(1)) begin
            state_d    = S_DONE;
            res_data_d = sh_q;
          end else begin
            sh_a_d = sh_q;
          end
        end
      end
      S_DONE: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rem_q      <= '0;
      sh_a_q     <= '0;
      sh_s_q     <= '0;
      sh_dir_q   <= 1'b0;
      res_data_q <= '0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      sh_a_q     <= sh_a_d;
      sh_s_q     <= sh_s_d;
      sh_dir_q   <= sh_dir_d;
      res_data_q <= res_data_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign res_valid = (state_q == S_DONE);
  assign sh_en     = (state_q == S_ROT);
  assign sh_a      = sh_a_q;
  assign sh_s      = sh_s_q;
  assign sh_dir    = sh_dir_q;
  assign res_data  = res_data_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl: ideal rotator model on sh_*, scoreboard of expected results.
`timescale 1ns/1ps

module tb_shift_seq_ctrl;

  localparam int PASS_W = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [3:0]        cmd_a;
  logic [1:0]        cmd_amt;
  logic              cmd_dir;
  logic [PASS_W-1:0] cmd_pass;
  logic [3:0]        sh_a;
  logic [1:0]        sh_s;
  logic              sh_dir;
  logic              sh_en;
  logic [3:0]        sh_q;
  logic              res_valid;
  logic              res_ready;
  logic [3:0]        res_data;
`ifdef SHIFT_ABORT_EN
  logic              abort;
`endif

  typedef struct {
    logic [3:0] data;
    int         lat;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] trace_q[$];
  int         sh_en_cnt = 0;
  int         checks    = 0;
  int         errors    = 0;

  shift_seq_ctrl #(.PASS_W(PASS_W)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef SHIFT_ABORT_EN
    .abort     (abort),
`endif
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_a     (cmd_a),
    .cmd_amt   (cmd_amt),
    .cmd_dir   (cmd_dir),
    .cmd_pass  (cmd_pass),
    .sh_a      (sh_a),
    .sh_s      (sh_s),
    .sh_dir    (sh_dir),
    .sh_en     (sh_en),
    .sh_q      (sh_q),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] rot_model(input logic [3:0] a, input logic [1:0] s, input logic dir);
    logic [7:0] d;
    d = {a, a};
    if (dir) begin
      d = d << s;
      return d[7:4];
    end
    d = d >> s;
    return d[3:0];
  endfunction

  always_comb sh_q = sh_en ? rot_model(sh_a, sh_s, sh_dir) : 4'h0;

  // Records every cycle the rotator is enabled, sampled just after the edge that starts the cycle.
  always @(posedge clk) begin
    #1;
    if (sh_en === 1'b1) begin
      sh_en_cnt++;
      trace_q.push_back(sh_a);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send_cmd(input int a, input int amt, input int dir, input int pass);
    exp_t e;
    cmd_a     = 4'(a);
    cmd_amt   = 2'(amt);
    cmd_dir   = 1'(dir);
    cmd_pass  = PASS_W'(pass);
    cmd_valid = 1'b1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL cmd_ready_at_send: got %b expected 1", cmd_ready);
    end
    e.data = rot_model(4'(a), 2'((amt * pass) % 4), 1'(dir));
    e.lat  = pass + 1;
    exp_q.push_back(e);
    step();
    cmd_valid = 1'b0;
    cmd_a     = 4'($urandom_range(0, 15));
    cmd_pass  = PASS_W'($urandom_range(0, 7));
  endtask

  // Called right after send_cmd: counts edges from the accept edge (inclusive) until res_valid.
  task automatic wait_valid(input string name);
    int   lat;
    exp_t e;
    lat = 1;
    while (res_valid !== 1'b1 && lat < 64) begin
      step();
      lat++;
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s_scoreboard: got empty queue expected one entry", name);
      return;
    end
    e = exp_q.pop_front();
    if (res_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout: got res_valid=%b after %0d cycles expected 1", name, res_valid, lat);
      return;
    end
    checks++;
    if (res_data !== e.data) begin
      errors++;
      $display("FAIL %s_data: got %b expected %b", name, res_data, e.data);
    end
    checks++;
    if (lat != e.lat) begin
      errors++;
      $display("FAIL %s_latency: got %0d expected %0d", name, lat, e.lat);
    end
  endtask

  task automatic release_result(input string name);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_release: got res_valid=%b cmd_ready=%b expected 0 1", name, res_valid, cmd_ready);
    end
  endtask

  task automatic run_cmd(input string name, input int a, input int amt, input int dir, input int pass);
    send_cmd(a, amt, dir, pass);
    wait_valid(name);
    release_result(name);
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    cmd_valid = 1'b0;
    res_ready = 1'b0;
    cmd_a     = '0;
    cmd_amt   = '0;
    cmd_dir   = 1'b0;
    cmd_pass  = '0;
`ifdef SHIFT_ABORT_EN
    abort     = 1'b0;
`endif
    step();
    step();
    rst = 1'b0;
    checks++;
    if (cmd_ready !== 1'b1 || res_valid !== 1'b0 || res_data !== 4'h0 || sh_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got cmd_ready=%b res_valid=%b res_data=%h sh_en=%b expected 1 0 0 0",
               cmd_ready, res_valid, res_data, sh_en);
    end
    checks++;
    if (sh_a !== 4'h0 || sh_s !== 2'd0 || sh_dir !== 1'b0) begin
      errors++;
      $display("FAIL reset_sh: got sh_a=%h sh_s=%0d sh_dir=%b expected 0 0 0", sh_a, sh_s, sh_dir);
    end
  endtask

  task automatic test_single_pass();
    sh_en_cnt = 0;
    trace_q.delete();
    run_cmd("single", 4'b0001, 1, 1, 1);
    checks++;
    if (sh_en_cnt != 1 || trace_q.size() != 1 || trace_q[0] !== 4'b0001) begin
      errors++;
      $display("FAIL single_sh_en: got %0d enabled cycles expected 1 with sh_a=0001", sh_en_cnt);
    end
  endtask

  task automatic test_multi_pass();
    logic [3:0] want [3];
    want = '{4'b1000, 4'b0100, 4'b0010};
    sh_en_cnt = 0;
    trace_q.delete();
    send_cmd(4'b1000, 1, 0, 3);
    wait_valid("multi");
    checks++;
    if (trace_q.size() != 3) begin
      errors++;
      $display("FAIL multi_trace_len: got %0d expected 3", trace_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (trace_q[i] !== want[i]) begin
          errors++;
          $display("FAIL multi_sh_a[%0d]: got %b expected %b", i, trace_q[i], want[i]);
        end
      end
    end
    checks++;
    if (sh_en !== 1'b0 || sh_a !== 4'b0010 || sh_s !== 2'd1 || sh_dir !== 1'b0) begin
      errors++;
      $display("FAIL multi_hold: got sh_en=%b sh_a=%b sh_s=%0d sh_dir=%b expected 0 0010 1 0",
               sh_en, sh_a, sh_s, sh_dir);
    end
    release_result("multi");
  endtask

  task automatic test_zero_pass_backpressure();
    sh_en_cnt = 0;
    send_cmd(4'b1011, 2, 1, 0);
    wait_valid("zero");
    for (int i = 0; i < 5; i++) begin
      cmd_valid = (i % 2 == 0);
      cmd_a     = 4'b0101;
      cmd_pass  = PASS_W'(1);
      step();
      checks++;
      if (res_valid !== 1'b1 || res_data !== 4'b1011 || cmd_ready !== 1'b0) begin
        errors++;
        $display("FAIL zero_hold[%0d]: got res_valid=%b res_data=%b cmd_ready=%b expected 1 1011 0",
                 i, res_valid, res_data, cmd_ready);
      end
    end
    cmd_valid = 1'b0;
    release_result("zero");
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (res_valid !== 1'b0 || sh_en_cnt != 0) begin
      errors++;
      $display("FAIL zero_ignored: got res_valid=%b sh_en cycles=%0d expected 0 0", res_valid, sh_en_cnt);
    end
  endtask

  task automatic test_reset_mid_op();
    int seen;
    send_cmd(4'b0110, 2, 0, 5);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    void'(exp_q.pop_back());
    checks++;
    if (cmd_ready !== 1'b1 || res_valid !== 1'b0 || res_data !== 4'h0 || sh_en !== 1'b0) begin
      errors++;
      $display("FAIL midrst_state: got cmd_ready=%b res_valid=%b res_data=%h sh_en=%b expected 1 0 0 0",
               cmd_ready, res_valid, res_data, sh_en);
    end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (res_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL midrst_no_result: got %0d res_valid cycles expected 0", seen);
    end
    run_cmd("after_rst", 4'b0011, 3, 1, 1);
  endtask

  task automatic test_boundaries();
    run_cmd("max_pass", 4'b0001, 1, 0, 7);
    run_cmd("amt_zero", 4'b0101, 0, 1, 2);
    run_cmd("full_turn", 4'b1100, 2, 1, 2);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      run_cmd("b2b", int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
    end
  endtask

`ifdef SHIFT_ABORT_EN
  task automatic test_abort();
    logic [3:0] prev;
    prev      = res_data;
    sh_en_cnt = 0;
    send_cmd(4'b0001, 1, 1, 7);
    step();
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    void'(exp_q.pop_back());
    checks++;
    if (cmd_ready !== 1'b1 || res_valid !== 1'b0 || sh_en !== 1'b0 || res_data !== prev || sh_en_cnt != 3) begin
      errors++;
      $display("FAIL abort_state: got cmd_ready=%b res_valid=%b sh_en=%b res_data=%b rot=%0d expected 1 0 0 %b 3",
               cmd_ready, res_valid, sh_en, res_data, sh_en_cnt, prev);
    end
    run_cmd("after_abort", 4'b1001, 1, 0, 2);
  endtask
`endif

  initial begin
    test_reset();
    test_single_pass();
    test_multi_pass();
    test_zero_pass_backpressure();
    test_reset_mid_op();
    test_boundaries();
`ifdef SHIFT_ABORT_EN
    test_abort();
`endif
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
